// File: rtl/sort_sched_pkg.sv
// Shared types and helpers for the sort job scheduler.
//   sched_state_e  : scheduler FSM states
//   WORDS_PER_JOB  : words per sort job (the sorter depth)
//   id_width(n)    : width of a requester index, never below 1 bit
package sort_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    RESP = 2'd3
  } sched_state_e;

  localparam int WORDS_PER_JOB = 8;

  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sort_job_scheduler_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr_i and wraps
// modulo N; the first asserted request in that order wins.
//   req_i     : request vector
//   ptr_i     : index where the search starts
//   gnt_o     : one-hot grant (zero when nothing requests)
//   gnt_idx_o : index of the winner
//   any_o     : at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [PW-1:0] idx_s;
  logic          hit_s;

  // Walk the requests in rotated order and keep only the first hit.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s        = PW'((32'(ptr_i) + 32'(k)) % 32'(N));
      hit_s        = ~any_o & req_i[idx_s];
      gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
      gnt_idx_o    = hit_s ? idx_s : gnt_idx_o;
      any_o        = any_o | hit_s;
    end
  end

endmodule

// File: rtl/sort_job_scheduler.sv
// Shares one 8-word sorter between NREQ requesters, one whole job at a time.
// A round-robin winner streams 8 words into the sorter (sortit low on each
// accepted beat), the sorter is then left sorting for SORT_LAT cycles, and the
// sorted vector is returned with the owner's ID on a valid/ready channel.
//   clk, resetn            : clock and async active-low reset (shared with sorter)
//   req_valid/data/ready   : per-requester word channel, slice i = requester i
//   srt_din, srt_sortit    : sorter write data and mode (low = capture din)
//   srt_dout               : sorter result, MSB is its valid flag
//   rsp_valid/ready        : response handshake
//   rsp_data/id/err        : sorted vector, owner, sorter-not-valid flag
//   busy                   : scheduler not idle
module sort_job_scheduler
  import sort_sched_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int SORT_LAT = 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [NREQ-1:0]                     req_valid,
  input  logic [NREQ*BITWIDTH-1:0]            req_data,
  output logic [NREQ-1:0]                     req_ready,
  output logic [BITWIDTH-1:0]                 srt_din,
  output logic                                srt_sortit,
  input  logic [WORDS_PER_JOB*BITWIDTH:0]     srt_dout,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [WORDS_PER_JOB*BITWIDTH-1:0]   rsp_data,
  output logic [id_width(NREQ)-1:0]           rsp_id,
  output logic                                rsp_err,
  output logic                                busy
);

  localparam int IDW = id_width(NREQ);
  localparam int LW  = id_width(SORT_LAT);
  localparam int VW  = WORDS_PER_JOB * BITWIDTH;

  sched_state_e  state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [NREQ-1:0] grant_oh_q, grant_oh_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]      beat_q, beat_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [VW-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]     arb_gnt_s;
  logic [IDW-1:0]      arb_idx_s;
  logic                arb_any_s;
  logic [BITWIDTH-1:0] sel_word_s;
  logic                accept_s;

  rr_arbiter #(
    .N  (NREQ),
    .PW (IDW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s),
    .any_o     (arb_any_s)
  );

  // Select the granted requester's word; the grant is one-hot so OR-ing is a mux.
  always_comb begin
    sel_word_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_word_s = sel_word_s | ({BITWIDTH{grant_oh_q[i]}} & req_data[i*BITWIDTH +: BITWIDTH]);
    end
  end

  assign accept_s = (state_q == LOAD) && (|(req_valid & grant_oh_q));

  // Sorter drive: sortit drops only on an accepted beat so stalls never write.
  always_comb begin
    if (accept_s) begin
      srt_din    = sel_word_s;
      srt_sortit = 1'b0;
    end else begin
      srt_din    = '0;
      srt_sortit = 1'b1;
    end
  end

  // Requester handshake and status decode from registered state.
  always_comb begin
    if (state_q == LOAD) begin
      req_ready = grant_oh_q;
    end else begin
      req_ready = '0;
    end
    busy      = (state_q != IDLE);
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    rsp_err   = rsp_err_q;
  end

  // Next-state logic for the job FSM and its counters.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        // No word is taken this cycle; the grant is only latched.
        if (arb_any_s) begin
          grant_d    = arb_idx_s;
          grant_oh_d = arb_gnt_s;
          state_d    = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          beat_d = beat_q + 3'd1;
          // The 8th beat wraps the counter, matching the sorter's write pointer.
          if (beat_q == 3'd7) begin
            state_d  = SORT;
            lat_d    = '0;
            rr_ptr_d = (grant_q == IDW'(NREQ - 1)) ? '0 : (grant_q + IDW'(1));
          end else begin
            state_d = LOAD;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      SORT: begin
        if (lat_q == LW'(SORT_LAT - 1)) begin
          rsp_data_d  = srt_dout[VW-1:0];
          rsp_err_d   = ~srt_dout[VW];
          rsp_id_d    = grant_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      beat_q      <= 3'd0;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Testbench for sort_job_scheduler with a behavioural 8-word sorter attached.
module tb_sort_job_scheduler;

  localparam int BW  = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int SL  = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N-1:0]      req_valid;
  logic [N*BW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [BW-1:0]     srt_din;
  logic              srt_sortit;
  logic [8*BW:0]     srt_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [8*BW-1:0]   rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              busy;

  always #5 clk = ~clk;

  sort_job_scheduler #(.BITWIDTH(BW), .NREQ(N), .SORT_LAT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .srt_din(srt_din), .srt_sortit(srt_sortit), .srt_dout(srt_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- behavioural sorter ----------------
  logic [BW-1:0] smem [8];
  logic [2:0]    swp;

  function automatic logic [63:0] bubble(input logic [63:0] v);
    logic [7:0] a [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  function automatic logic [63:0] mem_vec();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = smem[i];
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      swp <= 3'd0;
      srt_dout <= '0;
      for (int i = 0; i < 8; i++) smem[i] <= '0;
    end else if (!srt_sortit) begin
      smem[swp] <= srt_din;
      swp <= swp + 3'd1;
      srt_dout[8*BW] <= 1'b0;
    end else begin
      srt_dout <= {1'b1, bubble(mem_vec())};
    end
  end

  // ---------------- bench state and reference model ----------------
  int total = 0;
  int bad   = 0;

  logic [BW-1:0] job_w [N][8];
  int  beat [N];
  int  stall [N];
  bit  has_job [N];
  bit  pending [N];
  bit  stall_dir [N];
  bit  stall_rand;
  int  ref_ptr, bp_left, bp_seen, sortlow_cnt, cyc, rsp_cyc, c0;
  int  id_log [$];
  logic [63:0]    last_rsp;
  logic [IDW-1:0] last_id;
  logic           last_err;
  bit             hold_q;
  logic [63:0]    hold_data;
  logic [IDW-1:0] hold_id;
  logic           hold_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result: the job's words in ascending order, smallest in the low word.
  function automatic logic [63:0] ref_sorted(input int id);
    logic [7:0] q [$];
    logic [63:0] r;
    for (int k = 0; k < 8; k++) q.push_back(job_w[id][k]);
    q.sort();
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = q[k];
    return r;
  endfunction

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) p = p | pending[i];
    return p;
  endfunction

  // Words are listed in send order, first word in the top byte.
  task automatic post_job(input int id, input logic [63:0] w, input bit st);
    for (int k = 0; k < 8; k++) job_w[id][k] = w[63 - 8*k -: 8];
    has_job[id] = 1'b1; pending[id] = 1'b1;
    beat[id] = 0; stall[id] = 0; stall_dir[id] = st;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      has_job[i] = 1'b0; pending[i] = 1'b0; beat[i] = 0; stall[i] = 0; stall_dir[i] = 1'b0;
    end
    ref_ptr = 0; sortlow_cnt = 0; hold_q = 1'b0; bp_left = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    clear_model();
    for (int r = 0; r < 2; r++) begin
      #1;
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_srt_din"}, srt_din, 0);
      check({tag, "_srt_sortit"}, srt_sortit, 1);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
      check({tag, "_rsp_id"}, rsp_id, 0);
      check({tag, "_rsp_err"}, rsp_err, 0);
      check({tag, "_busy"}, busy, 0);
      @(negedge clk);
    end
    resetn = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0]    v;
    logic [N-1:0]    acc;
    logic [N*BW-1:0] d;
    int exp_id;
    @(negedge clk);
    v = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (has_job[i] && beat[i] < 8 && stall[i] == 0) v[i] = 1'b1;
      if (beat[i] < 8) d[i*BW +: BW] = job_w[i][beat[i]];
    end
    req_valid = v; req_data = d;
    rsp_ready = !(rsp_valid && bp_left > 0);
    #1;
    acc = req_valid & req_ready;
    check("ready_onehot0", $onehot0(req_ready), 1);
    check("sortit_vs_accept", srt_sortit, ~|acc);
    for (int i = 0; i < N; i++)
      if (acc[i]) check("din_word", srt_din, job_w[i][beat[i]]);
    if (acc != '0) sortlow_cnt++;
    if (hold_q) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, hold_data);
      check("hold_id", rsp_id, hold_id);
      check("hold_err", rsp_err, hold_err);
    end
    if (rsp_valid) begin
      check("busy_in_rsp", busy, 1);
      check("no_grant_in_rsp", req_ready, 0);
    end
    hold_q = rsp_valid && !rsp_ready;
    hold_data = rsp_data; hold_id = rsp_id; hold_err = rsp_err;
    if (rsp_valid && !rsp_ready) begin bp_left--; bp_seen++; end
    if (rsp_valid && rsp_ready) begin
      exp_id = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ref_ptr + k) % N;
        if (exp_id < 0 && pending[idx]) exp_id = idx;
      end
      check("rsp_expected", exp_id >= 0, 1);
      if (exp_id >= 0) begin
        check("rsp_id", rsp_id, exp_id);
        check("rsp_data", rsp_data, ref_sorted(exp_id));
        check("rsp_err", rsp_err, 0);
        check("beats_per_job", sortlow_cnt, 8);
        pending[exp_id] = 1'b0; has_job[exp_id] = 1'b0;
        ref_ptr = (exp_id + 1) % N;
      end
      sortlow_cnt = 0;
      last_rsp = rsp_data; last_id = rsp_id; last_err = rsp_err;
      rsp_cyc = cyc;
      id_log.push_back(int'(rsp_id));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        beat[i]++;
        if (stall_dir[i] && (beat[i] == 3 || beat[i] == 6)) stall[i] = 4;
        else if (stall_rand && beat[i] < 8 && $urandom_range(0, 3) == 0) stall[i] = $urandom_range(1, 3);
      end else if (stall[i] > 0) begin
        stall[i]--;
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input int max);
    int n = 0;
    while ((any_pending() || busy) && n < max) begin
      step();
      n++;
    end
    check("drain_timeout", any_pending() || busy, 0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    resetn = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    cyc = 0; bp_seen = 0; stall_rand = 1'b0; last_rsp = '0; last_id = '0; last_err = 1'b0;
    clear_model();
    do_reset("por");

    // Single job, back-to-back words; minimum job period.
    c0 = cyc;
    post_job(0, 64'h0801070206030504, 1'b0);
    run_until_done(60);
    check("t1_data", last_rsp, 64'h0807060504030201);
    check("t1_id", last_id, 0);
    check("t1_err", last_err, 0);
    check("t1_period", rsp_cyc - c0, 11);

    // Contention from a fresh pointer, then req1/req3 with pointer back at 0.
    do_reset("t2");
    id_log.delete();
    for (int i = 0; i < N; i++) post_job(i, {$urandom, $urandom}, 1'b0);
    run_until_done(200);
    check("t2_count", id_log.size(), 4);
    for (int k = 0; k < 4; k++) check("t2_order", id_log[k], k);
    id_log.delete();
    post_job(3, {$urandom, $urandom}, 1'b0);
    post_job(1, {$urandom, $urandom}, 1'b0);
    run_until_done(100);
    check("t2b_count", id_log.size(), 2);
    check("t2b_first", id_log[0], 1);
    check("t2b_second", id_log[1], 3);

    // Stalls after beats 3 and 6 add exactly 8 cycles and change nothing else.
    c0 = cyc;
    post_job(2, 64'h0801070206030504, 1'b1);
    run_until_done(80);
    check("t3_data", last_rsp, 64'h0807060504030201);
    check("t3_id", last_id, 2);
    check("t3_period", rsp_cyc - c0, 19);

    // Response backpressure with another requester waiting.
    bp_seen = 0; bp_left = 10;
    post_job(0, {$urandom, $urandom}, 1'b0);
    post_job(3, {$urandom, $urandom}, 1'b0);
    run_until_done(120);
    check("t4_bp_cycles", bp_seen, 10);

    // Reset in the middle of a load; the partial job never responds.
    post_job(0, 64'h1122334455667788, 1'b0);
    for (int n = 0; n < 30 && beat[0] < 5; n++) step();
    check("t5_reached_beat5", beat[0], 5);
    do_reset("t5");
    post_job(1, 64'h5A0011FF7E803C01, 1'b0);
    run_until_done(60);
    check("t5_data", last_rsp, 64'hFF807E5A3C110100);
    check("t5_id", last_id, 1);

    // Boundary data values.
    post_job(3, 64'h0000000000000000, 1'b0);
    run_until_done(60);
    check("t6_zero", last_rsp, 64'h0000000000000000);
    check("t6_zero_err", last_err, 0);
    post_job(0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    run_until_done(60);
    check("t6_ones", last_rsp, 64'hFFFFFFFFFFFFFFFF);
    check("t6_ones_err", last_err, 0);

    // Random batches: random requester subsets, data, stalls and backpressure.
    stall_rand = 1'b1;
    for (int b = 0; b < 15; b++) begin
      int mask;
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++)
        if (mask[i]) post_job(i, {$urandom, $urandom}, 1'b0);
      bp_left = $urandom_range(0, 3);
      run_until_done(400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
